apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

APB4 initiator that converts single-beat command requests into APB read/write transfers toward the timer register block and its peers on the 12-bit peripheral bus. It owns the SETUP/ACCESS sequencing, wait-state handling, PSLVERR capture and an access-timeout watchdog. Results go back to the requester through a valid/ready response channel. It sits between the system CPU/bridge side and the timer's APB slave port.

## Interface
Parameters:
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width; pstrb width is DATA_W/8
- TIMEOUT_CYC, 256, maximum ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
- sys_clk  in  1  single clock; all logic on the rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  pslverr seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- apb_psel, apb_penable, apb_pwrite  out  1 each  APB control
- apb_paddr  out  ADDR_W;  apb_pwdata  out  DATA_W;  apb_pstrb  out  DATA_W/8
- apb_prdata  in  DATA_W;  apb_pready  in  1;  apb_pslverr  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, all APB outputs 0. On acceptance, latch write, addr, wdata and strb, and go to SETUP.
- SETUP (one cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the latch. Always go to ACCESS.
- ACCESS: psel=1, penable=1, with all other APB outputs held stable.
  - pready=1 at the edge: capture prdata (reads only, else 0) and pslverr into rsp_err. rsp_timeout=0. Go to RESP.
  - pready=0: increment the wait counter.
  - Counter reaching TIMEOUT_CYC (TIMEOUT_CYC≠0): abort. rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
- RESP: rsp_valid=1, APB outputs back to 0. On rsp_ready, go to IDLE.
- pstrb is driven 0 on reads (APB4 rule). pwdata is driven 0 on reads.
- The wait counter is $clog2(TIMEOUT_CYC+1) bits, cleared on entry to SETUP, and saturates.
- pslverr and prdata are sampled only when psel & penable & pready. They are ignored in every other state.

## Timing
- Reset (asynchronous, any state): state=IDLE. cmd_ready=0 while reset is asserted, then 1 in the first IDLE cycle. rsp_valid, rsp_err, rsp_timeout, rsp_rdata and all APB outputs are 0. An in-flight transfer is dropped with no response.
- Accept at edge E0. SETUP spans E0..E1. ACCESS starts at E1.
- Zero-wait slave (pready=1 at E2): rsp_valid is asserted after E2.
- Each cycle of pready=0 adds one cycle.
- Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP with rsp_ready held at 1).
- penable never rises in the same cycle psel rises.
- Timeout with TIMEOUT_CYC=N: abort at the N-th ACCESS edge with pready=0. psel drops at that edge.
- If pready=1 arrives on the same edge the counter reaches N, the completion wins and rsp_timeout=0.
- cmd_ready=0 outside IDLE. A cmd_valid held high while busy is accepted on return to IDLE.
- Response fields are stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- After reset, read 0x000 then 0x00C from the timer (zero wait) -> rsp_rdata 0x0000_0100, then 0xFFFF_FFFF; rsp_err=0. psel→penable spacing is exactly 1 cycle, and each response comes 3 cycles after acceptance.
- Write 0x014 ← 0x0000_0001 with strb 0xF, then read it back -> rsp_rdata 0x0000_0001. During the read, pstrb=0 and pwdata=0.
- Slave holds pready=0 for 3 ACCESS cycles -> paddr, pwdata and pstrb stay stable throughout; rsp_valid asserts 6 cycles after acceptance.
- Slave returns pslverr=1 with pready on a write to 0x018 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0. The next command completes cleanly with rsp_err=0.
- TIMEOUT_CYC=16, pready stuck at 0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1; psel=0 the following cycle. Repeat with pready rising exactly on the 16th edge -> normal completion, rsp_timeout=0.
- Assert sys_rst_n low during ACCESS, with rsp_ready=0 and a back-to-back cmd_valid pending -> all outputs are 0 immediately. After release, cmd_ready=1 and the pending command is accepted; no stale response appears.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB4 initiator: turns single-beat command requests into APB transfers with
// wait-state handling, PSLVERR capture and an ACCESS-phase timeout watchdog.
module apb_master_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [ADDR_W-1:0]   apb_paddr,
  output logic [DATA_W-1:0]   apb_pwdata,
  output logic [DATA_W/8-1:0] apb_pstrb,
  input  logic [DATA_W-1:0]   apb_prdata,
  input  logic                apb_pready,
  input  logic                apb_pslverr
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_strb;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic                  r_timeout;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_to_hit;

  assign w_accept = cmd_valid && cmd_ready;
  // Completion is only meaningful in ACCESS; pready elsewhere is ignored.
  assign w_done   = (r_state == S_ACCESS) && apb_pready;
  // Abort on the edge where this would be the TIMEOUT_CYC-th wait cycle;
  // a simultaneous pready takes priority via w_done.
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_state == S_ACCESS) && !apb_pready &&
                    (r_cnt == CNT_LIM);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_to_hit) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Command latch: data only, qualified by the state machine, so no reset.
  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
      r_strb  <= cmd_strb;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !apb_pready && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_rdata   <= r_write ? '0 : apb_prdata;
        r_err     <= apb_pslverr;
        r_timeout <= 1'b0;
      end else if (w_to_hit) begin
        r_rdata   <= '0;
        r_err     <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  // cmd_ready is forced low while reset is held, even though state is IDLE.
  assign cmd_ready   = (r_state == S_IDLE) && sys_rst_n;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign rsp_timeout = r_timeout;

  assign apb_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign apb_penable = (r_state == S_ACCESS);
  assign apb_pwrite  = apb_psel && r_write;
  assign apb_paddr   = apb_psel ? r_addr : '0;
  // Reads drive zero strobes and zero write data.
  assign apb_pwdata  = (apb_psel && r_write) ? r_wdata : '0;
  assign apb_pstrb   = (apb_psel && r_write) ? r_strb  : '0;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: APB slave model, response scoreboard
// and a protocol monitor, with a 16-cycle timeout instance.
module tb_apb_master_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 16;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [ADDR_W-1:0] apb_paddr;
  logic [DATA_W-1:0] apb_pwdata;
  logic [3:0]        apb_pstrb;
  logic [DATA_W-1:0] apb_prdata;
  logic              apb_pready;
  logic              apb_pslverr;

  apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t sb[$];

  // Slave model: register file with configurable wait states, error and stall.
  logic [31:0] mem [0:15];
  int          wcnt;
  int          sl_wait;
  logic        sl_err;
  logic        sl_stuck;
  logic        w_acc;

  assign w_acc       = apb_psel && apb_penable;
  assign apb_pready  = w_acc && !sl_stuck && (wcnt >= sl_wait);
  assign apb_prdata  = w_acc ? mem[apb_paddr[5:2]] : 32'hDEAD_BEEF;
  assign apb_pslverr = sl_err || !apb_pready;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_0100;
      mem[3] <= 32'hFFFF_FFFF;
      wcnt   <= 0;
    end else begin
      if (w_acc && !apb_pready) wcnt <= wcnt + 1;
      else                      wcnt <= 0;
      if (apb_pready && apb_pwrite && !sl_err) begin
        for (int b = 0; b < 4; b++)
          if (apb_pstrb[b]) mem[apb_paddr[5:2]][8*b +: 8] <= apb_pwdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: psel/penable sequencing, ACCESS stability, read zeroing,
  // and response stability under backpressure.
  logic              p_psel, p_pen, p_pwrite, p_rspv, p_rspr, p_err, p_to;
  logic [ADDR_W-1:0] p_paddr;
  logic [31:0]       p_pwdata, p_rdata;
  logic [3:0]        p_pstrb;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (apb_penable) chk("mon_pen_after_psel", 64'(p_psel), 64'd1);
      if (p_psel && !p_pen) chk("mon_setup_to_access", 64'(apb_penable), 64'd1);
      if (apb_penable && p_psel) begin
        chk("mon_paddr_stable", 64'(apb_paddr), 64'(p_paddr));
        chk("mon_pwdata_stable", 64'(apb_pwdata), 64'(p_pwdata));
        chk("mon_pstrb_stable", 64'(apb_pstrb), 64'(p_pstrb));
        chk("mon_pwrite_stable", 64'(apb_pwrite), 64'(p_pwrite));
      end
      if (apb_psel && !apb_pwrite) chk("mon_read_zero", 64'({apb_pstrb, apb_pwdata}), 64'd0);
      if (p_rspv && !p_rspr && rsp_valid)
        chk("mon_rsp_stable", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({p_rdata, p_err, p_to}));
    end
    p_psel   <= apb_psel;
    p_pen    <= apb_penable;
    p_pwrite <= apb_pwrite;
    p_paddr  <= apb_paddr;
    p_pwdata <= apb_pwdata;
    p_pstrb  <= apb_pstrb;
    p_rspv   <= rsp_valid;
    p_rspr   <= rsp_ready;
    p_rdata  <= rsp_rdata;
    p_err    <= rsp_err;
    p_to     <= rsp_timeout;
  end

  task automatic wait_rsp(input string tag, input int t_acc, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (rsp_valid) begin
      chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(lat));
      chk({tag, "_apb_idle"}, 64'({apb_psel, apb_penable}), 64'd0);
      if (sb.size() == 0) begin
        chk({tag, "_sb_has_entry"}, 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
        chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
        if (!rsp_ready) begin
          repeat (2) @(negedge sys_clk);
          chk({tag, "_held_valid"}, 64'(rsp_valid), 64'd1);
          chk({tag, "_held_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
          rsp_ready = 1'b1;
        end
      end
      @(negedge sys_clk);
      chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  task automatic do_cmd(input string tag, input logic w, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] erd, input logic eerr, input logic eto,
                        input int lat);
    int n;
    int t_acc;
    sb.push_back('{rdata: erd, err: eerr, to: eto});
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_accept"}, 64'(cmd_ready), 64'd1);
    t_acc = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk({tag, "_setup"}, 64'({apb_psel, apb_penable, apb_paddr}), 64'({2'b10, a}));
    wait_rsp(tag, t_acc, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b1;
    sl_wait   = 0;
    sl_err    = 1'b0;
    sl_stuck  = 1'b0;

    repeat (3) @(negedge sys_clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    chk("rst_apb", 64'({apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pstrb}), 64'd0);
    sys_rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);
    @(negedge sys_clk);

    do_cmd("rd_000", 1'b0, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 1'b0, 3);
    do_cmd("rd_00c", 1'b0, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);
    do_cmd("wr_014", 1'b1, 12'h014, 32'h0000_0001, 4'hF, 32'h0, 1'b0, 1'b0, 3);
    do_cmd("rd_014", 1'b0, 12'h014, 32'hCAFE_F00D, 4'hF, 32'h0000_0001, 1'b0, 1'b0, 3);

    sl_wait = 3;
    do_cmd("wr_010_wait", 1'b1, 12'h010, 32'hA5A5_5A5A, 4'h5, 32'h0, 1'b0, 1'b0, 6);
    do_cmd("rd_010_wait", 1'b0, 12'h010, 32'h0, 4'h0, 32'h00A5_005A, 1'b0, 1'b0, 6);
    sl_wait = 0;

    sl_err = 1'b1;
    do_cmd("wr_018_slverr", 1'b1, 12'h018, 32'h0000_1234, 4'hF, 32'h0, 1'b1, 1'b0, 3);
    sl_err = 1'b0;
    do_cmd("rd_after_err", 1'b0, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 1'b0, 3);
    do_cmd("rd_018_unwritten", 1'b0, 12'h018, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 3);

    sl_stuck = 1'b1;
    do_cmd("rd_timeout", 1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, TO_CYC + 2);
    sl_stuck = 1'b0;
    sl_wait = TO_CYC - 1;
    do_cmd("rd_ready_on_limit", 1'b0, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, TO_CYC + 2);
    sl_wait = 0;

    // Reset in ACCESS with a pending back-to-back command and backpressure.
    sl_stuck  = 1'b1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h000;
    @(negedge sys_clk);
    cmd_addr  = 12'h00C;
    @(negedge sys_clk);
    chk("rstmid_in_access", 64'({apb_psel, apb_penable}), 64'd3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstmid_rsp_zero", 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    chk("rstmid_apb_ctl_zero", 64'({apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pstrb}), 64'd0);
    chk("rstmid_pwdata_zero", 64'(apb_pwdata), 64'd0);
    repeat (2) @(negedge sys_clk);
    sl_stuck = 1'b0;
    #2 sys_rst_n = 1'b1;
    #1;
    chk("rstmid_release_ready", 64'(cmd_ready), 64'd1);
    sb.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b0, to: 1'b0});
    begin
      int t_acc;
      t_acc = cyc;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      chk("rstmid_pending_setup", 64'({apb_psel, apb_penable, apb_paddr}), 64'({2'b10, 12'h00C}));
      wait_rsp("rstmid_pending", t_acc, 3);
    end

    repeat (3) @(negedge sys_clk);
    chk("end_no_stale_rsp", 64'(rsp_valid), 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
